// File: rtl/regfile_sort_ctrl_if.sv
// Register file access bus for the sort controller: combinational read port
// plus a write port that commits at the next clock edge.
interface regfile_sort_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] R_Addr;
   logic              R_en;
   logic [DATA_W-1:0] R_Data;
   logic [ADDR_W-1:0] W_Addr;
   logic              W_en;
   logic [DATA_W-1:0] W_Data;

   modport master (output R_Addr, output R_en, input R_Data,
                   output W_Addr, output W_en, output W_Data);
   modport slave  (input R_Addr, input R_en, output R_Data,
                   input W_Addr, input W_en, input W_Data);
endinterface

// File: rtl/regfile_sort_ctrl.sv
// In-place ascending bubble sort of a register file with a shrinking pass
// limit and early exit; reports completion with a Done pulse and swap count.
module regfile_sort_ctrl #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Start,
   output logic                    Busy,
   output logic                    Done,
   output logic [CNT_W-1:0]        Swap_Cnt,
   regfile_sort_ctrl_if.master     rf_bus
);
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_B = 3'd2,
      ST_WR_A = 3'd3,
      ST_WR_B = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  MAX_C  = {CNT_W{1'b1}};

   state_t              state_r, state_s, adv_state_s;
   logic [ADDR_W-1:0]   j_r, j_s, adv_j_s;
   logic [ADDR_W-1:0]   limit_r, limit_s, adv_limit_s;
   logic [DATA_W-1:0]   a_r, a_s, b_r, b_s;
   logic                swapped_r, swapped_s, adv_swapped_s, adv_sw_any_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic                busy_r, busy_s, done_r, done_s;
   logic                r_en_r, r_en_s, w_en_r, w_en_s;
   logic [ADDR_W-1:0]   r_addr_r, r_addr_s, w_addr_r, w_addr_s;
   logic [DATA_W-1:0]   w_data_r, w_data_s;

   // End-of-compare decision: next pair, next (shorter) pass, or finish.
   always_comb begin
      adv_sw_any_s  = swapped_r | (state_r == ST_WR_B);
      adv_state_s   = ST_RD_A;
      adv_j_s       = j_r;
      adv_limit_s   = limit_r;
      adv_swapped_s = adv_sw_any_s;
      if ((j_r + ONE_A) < limit_r) begin
         adv_j_s = j_r + ONE_A;
      end else if (!adv_sw_any_s || (limit_r == ONE_A)) begin
         adv_state_s = ST_DONE;
      end else begin
         adv_limit_s   = limit_r - ONE_A;
         adv_j_s       = '0;
         adv_swapped_s = 1'b0;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_s   = state_r;
      j_s       = j_r;
      limit_s   = limit_r;
      a_s       = a_r;
      b_s       = b_r;
      swapped_s = swapped_r;
      cnt_s     = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (Start) begin
               j_s       = '0;
               limit_s   = LAST_A;
               swapped_s = 1'b0;
               cnt_s     = '0;
               state_s   = ST_RD_A;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD_A: begin
            a_s     = rf_bus.R_Data;
            state_s = ST_RD_B;
         end
         ST_RD_B: begin
            b_s = rf_bus.R_Data;
            // Strict compare: equal values stay put.
            if (a_r > rf_bus.R_Data) begin
               state_s = ST_WR_A;
            end else begin
               state_s   = adv_state_s;
               j_s       = adv_j_s;
               limit_s   = adv_limit_s;
               swapped_s = adv_swapped_s;
            end
         end
         ST_WR_A: state_s = ST_WR_B;
         ST_WR_B: begin
            cnt_s     = (cnt_r == MAX_C) ? cnt_r : (cnt_r + ONE_C);
            state_s   = adv_state_s;
            j_s       = adv_j_s;
            limit_s   = adv_limit_s;
            swapped_s = adv_swapped_s;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Output values for the state being entered, so outputs come straight from flops.
   always_comb begin
      busy_s   = 1'b0;
      done_s   = 1'b0;
      r_en_s   = 1'b0;
      r_addr_s = '0;
      w_en_s   = 1'b0;
      w_addr_s = '0;
      w_data_s = '0;
      case (state_s)
         ST_IDLE: busy_s = 1'b0;
         ST_RD_A: begin
            busy_s   = 1'b1;
            r_en_s   = 1'b1;
            r_addr_s = j_s;
         end
         ST_RD_B: begin
            busy_s   = 1'b1;
            r_en_s   = 1'b1;
            r_addr_s = j_s + ONE_A;
         end
         ST_WR_A: begin
            busy_s   = 1'b1;
            w_en_s   = 1'b1;
            w_addr_s = j_s;
            w_data_s = b_s;
         end
         ST_WR_B: begin
            busy_s   = 1'b1;
            w_en_s   = 1'b1;
            w_addr_s = j_s + ONE_A;
            w_data_s = a_s;
         end
         ST_DONE: done_s = 1'b1;
         default: busy_s = 1'b0;
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r   <= ST_IDLE;
         j_r       <= '0;
         limit_r   <= '0;
         a_r       <= '0;
         b_r       <= '0;
         swapped_r <= 1'b0;
         cnt_r     <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         r_en_r    <= 1'b0;
         r_addr_r  <= '0;
         w_en_r    <= 1'b0;
         w_addr_r  <= '0;
         w_data_r  <= '0;
      end else begin
         state_r   <= state_s;
         j_r       <= j_s;
         limit_r   <= limit_s;
         a_r       <= a_s;
         b_r       <= b_s;
         swapped_r <= swapped_s;
         cnt_r     <= cnt_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         r_en_r    <= r_en_s;
         r_addr_r  <= r_addr_s;
         w_en_r    <= w_en_s;
         w_addr_r  <= w_addr_s;
         w_data_r  <= w_data_s;
      end
   end

   assign Busy          = busy_r;
   assign Done          = done_r;
   assign Swap_Cnt      = cnt_r;
   assign rf_bus.R_en   = r_en_r;
   assign rf_bus.R_Addr = r_addr_r;
   assign rf_bus.W_en   = w_en_r;
   assign rf_bus.W_Addr = w_addr_r;
   assign rf_bus.W_Data = w_data_r;
endmodule

// File: tb/tb_regfile_sort_ctrl.sv
// Directed bench: behavioural 16x8 register file plus hand-computed expected
// arrays, swap counts and Done latencies.
module tb_regfile_sort_ctrl;
   logic       Clk = 1'b0;
   logic       Rst;
   logic       Start;
   logic       Busy;
   logic       Done;
   logic [7:0] Swap_Cnt;

   regfile_sort_ctrl_if #(.ADDR_W(4), .DATA_W(8)) rf_if ();

   regfile_sort_ctrl #(.DEPTH(16), .ADDR_W(4), .DATA_W(8), .CNT_W(8)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Start    (Start),
      .Busy     (Busy),
      .Done     (Done),
      .Swap_Cnt (Swap_Cnt),
      .rf_bus   (rf_if)
   );

   always #5 Clk = ~Clk;

   localparam logic [7:0] RST_VALS [16] = '{8'd57, 8'd55, 8'd54, 8'd53, 8'd51, 8'd50, 8'd49, 8'd48,
                                            8'd40, 8'd31, 8'd38, 8'd58, 8'd59, 8'd63, 8'd68, 8'd70};
   localparam logic [7:0] RST_SORTED [16] = '{8'd31, 8'd38, 8'd40, 8'd48, 8'd49, 8'd50, 8'd51, 8'd53,
                                              8'd54, 8'd55, 8'd57, 8'd58, 8'd59, 8'd63, 8'd68, 8'd70};

   logic [7:0] mem     [16];
   logic [7:0] pl_vals [16];
   logic [7:0] exp_arr [16];
   logic       pl_en;

   // Register file model: reset reload, bench preload, controller writes.
   always @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= RST_VALS[i];
      end else if (pl_en) begin
         for (int i = 0; i < 16; i++) mem[i] <= pl_vals[i];
      end else if (rf_if.W_en) begin
         mem[rf_if.W_Addr] <= rf_if.W_Data;
      end
   end
   assign rf_if.R_Data = mem[rf_if.R_Addr];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic preload();
      pl_en = 1'b1;
      @(posedge Clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic check_array(input string tag);
      for (int i = 0; i < 16; i++) check_eq($sformatf("%s[%0d]", tag, i), {24'd0, mem[i]}, {24'd0, exp_arr[i]});
   endtask

   // Pulse Start, then count cycles until Done; also counts write cycles and
   // checks Busy in cycle 1 and that Done drops afterwards.
   task automatic run_sort(input string tag, output int cyc, output int wr_cyc);
      cyc    = 0;
      wr_cyc = 0;
      Start  = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      for (int k = 1; k <= 2000; k++) begin
         if (k > 1) begin
            @(posedge Clk);
            #1;
         end
         if (k == 1) check_eq({tag, "_busy_c1"}, {31'd0, Busy}, 32'd1);
         if (rf_if.W_en) wr_cyc++;
         if (rf_if.W_en && rf_if.R_en) check_eq({tag, "_rw_excl"}, 32'd1, 32'd0);
         if (Done) begin
            cyc = k;
            break;
         end
      end
      check_eq({tag, "_done_seen"}, {31'd0, (cyc != 0)}, 32'd1);
      check_eq({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
      @(posedge Clk);
      #1 check_eq({tag, "_done_once"}, {31'd0, Done}, 32'd0);
   endtask

   int  cyc, wr_cyc, k_done;
   logic prev_wen;

   initial begin
      Rst   = 1'b1;
      Start = 1'b0;
      pl_en = 1'b0;
      for (int i = 0; i < 16; i++) pl_vals[i] = 8'd0;
      @(posedge Clk);
      @(posedge Clk);
      #1 Rst = 1'b0;
      check_eq("rst_busy",  {31'd0, Busy}, 32'd0);
      check_eq("rst_done",  {31'd0, Done}, 32'd0);
      check_eq("rst_cnt",   {24'd0, Swap_Cnt}, 32'd0);
      check_eq("rst_ren",   {31'd0, rf_if.R_en}, 32'd0);
      check_eq("rst_wen",   {31'd0, rf_if.W_en}, 32'd0);
      check_eq("rst_raddr", {28'd0, rf_if.R_Addr}, 32'd0);
      check_eq("rst_wdata", {24'd0, rf_if.W_Data}, 32'd0);

      // Reset contents: 54 inversions
      run_sort("rstc", cyc, wr_cyc);
      check_eq("rstc_cnt", {24'd0, Swap_Cnt}, 32'd54);
      check_eq("rstc_wr",  wr_cyc, 32'd108);
      exp_arr = RST_SORTED;
      check_array("rstc_arr");

      // Already sorted
      for (int i = 0; i < 16; i++) pl_vals[i] = 8'(i);
      preload();
      run_sort("sorted", cyc, wr_cyc);
      check_eq("sorted_cyc", cyc, 32'd31);
      check_eq("sorted_wr",  wr_cyc, 32'd0);
      check_eq("sorted_cnt", {24'd0, Swap_Cnt}, 32'd0);

      // Reverse sorted
      for (int i = 0; i < 16; i++) pl_vals[i] = 8'(15 - i);
      preload();
      run_sort("rev", cyc, wr_cyc);
      check_eq("rev_cyc", cyc, 32'd481);
      check_eq("rev_cnt", {24'd0, Swap_Cnt}, 32'd120);
      for (int i = 0; i < 16; i++) exp_arr[i] = 8'(i);
      check_array("rev_arr");

      // Duplicates: only the 0 moves, one swap per pass
      for (int i = 0; i < 16; i++) pl_vals[i] = (i == 15) ? 8'd0 : 8'd7;
      preload();
      run_sort("dup", cyc, wr_cyc);
      check_eq("dup_cnt", {24'd0, Swap_Cnt}, 32'd15);
      check_eq("dup_wr",  wr_cyc, 32'd30);
      for (int i = 0; i < 16; i++) exp_arr[i] = (i == 0) ? 8'd0 : 8'd7;
      check_array("dup_arr");

      // Start held high across a sort and into the next one
      preload();
      Start  = 1'b1;
      k_done = 0;
      for (int k = 1; k <= 2000; k++) begin
         @(posedge Clk);
         #1;
         if (Done) begin
            k_done = k;
            break;
         end
      end
      check_eq("hold_done_seen", {31'd0, (k_done != 0)}, 32'd1);
      check_eq("hold_cnt1", {24'd0, Swap_Cnt}, 32'd15);
      @(posedge Clk);
      #1 check_eq("hold_idle_busy", {31'd0, Busy}, 32'd0);
      check_eq("hold_idle_done", {31'd0, Done}, 32'd0);
      @(posedge Clk);
      #1 check_eq("hold_restart_busy", {31'd0, Busy}, 32'd1);
      check_eq("hold_restart_cnt", {24'd0, Swap_Cnt}, 32'd0);
      Start  = 1'b0;
      k_done = 0;
      for (int k = 2; k <= 2000; k++) begin
         @(posedge Clk);
         #1;
         if (Done) begin
            k_done = k;
            break;
         end
      end
      check_eq("hold_second_cyc", k_done, 32'd31);
      check_eq("hold_second_cnt", {24'd0, Swap_Cnt}, 32'd0);

      // Reset during WR_A of the fourth swap
      for (int i = 0; i < 16; i++) pl_vals[i] = 8'(15 - i);
      preload();
      Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      prev_wen = 1'b0;
      k_done   = 0;
      for (int k = 1; k <= 2000; k++) begin
         if (rf_if.W_en && !prev_wen && (Swap_Cnt == 8'd3)) begin
            k_done = k;
            break;
         end
         prev_wen = rf_if.W_en;
         @(posedge Clk);
         #1;
      end
      check_eq("wra_found", {31'd0, (k_done != 0)}, 32'd1);
      check_eq("wra_addr", {28'd0, rf_if.W_Addr}, 32'd3);
      Rst = 1'b1;
      @(posedge Clk);
      #1 Rst = 1'b0;
      check_eq("wra_rst_busy", {31'd0, Busy}, 32'd0);
      check_eq("wra_rst_wen",  {31'd0, rf_if.W_en}, 32'd0);
      check_eq("wra_rst_cnt",  {24'd0, Swap_Cnt}, 32'd0);
      run_sort("after_rst", cyc, wr_cyc);
      check_eq("after_rst_cnt", {24'd0, Swap_Cnt}, 32'd54);
      exp_arr = RST_SORTED;
      check_array("after_rst_arr");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
